tnn_neuron_scheduler: RTL and testbench

- Time-multiplexes one shared 5-operand, 3-bit threshold comparator (the approximate TNN neuron core) across NUM_NEURONS neurons for one feature sample.
- Per neuron, a programmable table selects which 5 sample features drive comparator operands a..e.
- Collects one result bit per neuron into a vector handed downstream via valid/ready.
- Sits between the feature quantiser and the TNN vote/aggregation stage.

---
 rtl/tnn_neuron_scheduler.sv | 174 +++++++++++++++++
 tb/tb_tnn_neuron_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_scheduler.sv
// Sequences NUM_NEURONS neurons through one shared 5-operand TNN comparator per sample.
// Optional TNN_SCHED_CMP_PIPE_EN registers the operands and adds a DRAIN state.
module tnn_neuron_scheduler #(
   parameter int NUM_FEAT    = 11,
   parameter int NUM_NEURONS = 8,
   parameter int IW          = $clog2(NUM_FEAT),
   parameter int NW          = $clog2(NUM_NEURONS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_FEAT*3-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    cfg_we,
   input  logic [NW-1:0]           cfg_neuron,
   input  logic [2:0]              cfg_slot,
   input  logic [IW-1:0]           cfg_idx,
   output logic                    cfg_err,
   output logic [2:0]              cmp_a,
   output logic [2:0]              cmp_b,
   output logic [2:0]              cmp_c,
   output logic [2:0]              cmp_d,
   output logic [2:0]              cmp_e,
   input  logic                    cmp_out,
   output logic [NUM_NEURONS-1:0]  out_vec,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
`ifdef TNN_SCHED_CMP_PIPE_EN
      S_DONE,
      S_DRAIN
`else
      S_DONE
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [NW-1:0]           k_q, k_d;
   logic [NUM_FEAT*3-1:0]   sample_q, sample_d;
   logic [NUM_NEURONS-1:0]  vec_q, vec_d;
   logic                    in_ready_q, in_ready_d;
   logic                    cfg_err_q, cfg_err_d;
   logic [IW-1:0]           cfg_q [NUM_NEURONS][5];
   logic [IW-1:0]           cfg_d [NUM_NEURONS][5];
   logic                    cfg_ok;
   logic [2:0]              ops [5];
   logic                    last_k;

   function automatic logic [2:0] feat(input logic [NUM_FEAT*3-1:0] s, input logic [IW-1:0] idx);
      feat = '0;
      for (int unsigned f = 0; f < NUM_FEAT; f++)
         if (idx == IW'(f)) feat = s[3*f +: 3];
   endfunction

   always_comb begin
      for (int unsigned s = 0; s < 5; s++)
         ops[s] = feat(sample_q, cfg_q[k_q][s]);
   end

   assign last_k = (k_q == NW'(NUM_NEURONS - 1));
   assign cfg_ok = cfg_we && (state_q == S_IDLE) && (32'(cfg_idx) < NUM_FEAT)
                   && (cfg_slot <= 3'd4) && (32'(cfg_neuron) < NUM_NEURONS);

`ifdef TNN_SCHED_CMP_PIPE_EN
   // Result for neuron k arrives one cycle after issue; capture index trails k_q.
   logic [2:0]    cmp_q [5];
   logic [2:0]    cmp_nx [5];
   logic          cap_v_q, cap_v_d;
   logic [NW-1:0] cap_k_q, cap_k_d;

   always_comb begin
      for (int unsigned s = 0; s < 5; s++)
         cmp_nx[s] = (state_q == S_RUN) ? ops[s] : '0;
      cap_v_d = (state_q == S_RUN);
      cap_k_d = k_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < 5; s++) cmp_q[s] <= '0;
         cap_v_q <= 1'b0;
         cap_k_q <= '0;
      end else begin
         for (int unsigned s = 0; s < 5; s++) cmp_q[s] <= cmp_nx[s];
         cap_v_q <= cap_v_d;
         cap_k_q <= cap_k_d;
      end
   end

   assign cmp_a = cmp_q[0];
   assign cmp_b = cmp_q[1];
   assign cmp_c = cmp_q[2];
   assign cmp_d = cmp_q[3];
   assign cmp_e = cmp_q[4];
`else
   assign cmp_a = (state_q == S_RUN) ? ops[0] : '0;
   assign cmp_b = (state_q == S_RUN) ? ops[1] : '0;
   assign cmp_c = (state_q == S_RUN) ? ops[2] : '0;
   assign cmp_d = (state_q == S_RUN) ? ops[3] : '0;
   assign cmp_e = (state_q == S_RUN) ? ops[4] : '0;
`endif

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      sample_d  = sample_q;
      vec_d     = vec_q;
      cfg_d     = cfg_q;
      cfg_err_d = cfg_we && !cfg_ok;
      if (cfg_ok) cfg_d[cfg_neuron][cfg_slot] = cfg_idx;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               sample_d = in_data;
               vec_d    = '0;
               k_d      = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
`ifndef TNN_SCHED_CMP_PIPE_EN
            vec_d[k_q] = cmp_out;
            if (last_k) state_d = S_DONE;
`else
            if (last_k) state_d = S_DRAIN;
`endif
            else k_d = k_q + NW'(1);
         end
`ifdef TNN_SCHED_CMP_PIPE_EN
         S_DRAIN: state_d = S_DONE;
`endif
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
`ifdef TNN_SCHED_CMP_PIPE_EN
      if (cap_v_q) vec_d[cap_k_q] = cmp_out;
`endif
      in_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         sample_q   <= '0;
         vec_q      <= '0;
         in_ready_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         for (int unsigned n = 0; n < NUM_NEURONS; n++)
            for (int unsigned s = 0; s < 5; s++)
               cfg_q[n][s] <= IW'((n + s) % NUM_FEAT);
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         sample_q   <= sample_d;
         vec_q      <= vec_d;
         in_ready_q <= in_ready_d;
         cfg_err_q  <= cfg_err_d;
         cfg_q      <= cfg_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign cfg_err   = cfg_err_q;
   assign out_vec   = vec_q;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tnn_neuron_scheduler.sv
// Scoreboard bench for tnn_neuron_scheduler: reference model of the config table and
// comparator predicts operands, result vector and latency for every accepted sample.
module tb_tnn_neuron_scheduler;

   localparam int NF = 11;
   localparam int NN = 8;
`ifdef TNN_SCHED_CMP_PIPE_EN
   localparam int LAT  = NN + 1;
   localparam int PIPE = 1;
`else
   localparam int LAT  = NN;
   localparam int PIPE = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [NF*3-1:0] in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           cfg_we = 1'b0;
   logic [2:0]     cfg_neuron = '0;
   logic [2:0]     cfg_slot = '0;
   logic [3:0]     cfg_idx = '0;
   logic           cfg_err;
   logic [2:0]     cmp_a, cmp_b, cmp_c, cmp_d, cmp_e;
   logic           cmp_out;
   logic [NN-1:0]  out_vec;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic           busy;

   tnn_neuron_scheduler #(.NUM_FEAT(NF), .NUM_NEURONS(NN)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_slot(cfg_slot), .cfg_idx(cfg_idx),
      .cfg_err(cfg_err), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_c(cmp_c), .cmp_d(cmp_d),
      .cmp_e(cmp_e), .cmp_out(cmp_out), .out_vec(out_vec), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   // Comparator core stand-in: fires when b+c+e outweighs a+d.
   assign cmp_out = (5'(cmp_b) + 5'(cmp_c) + 5'(cmp_e)) > (5'(cmp_a) + 5'(cmp_d));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NN-1:0]        vec;
      int                   acc;
      logic [NN-1:0][14:0]  ops;
   } exp_t;

   exp_t exp_q[$];
   int   cfg_m [NN][5];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic void cfg_default();
      for (int n = 0; n < NN; n++)
         for (int s = 0; s < 5; s++) cfg_m[n][s] = (n + s) % NF;
   endfunction

   function automatic bit cfg_apply(input int n, input int sl, input int ix, input bit idle);
      bit ok;
      ok = idle && (ix < NF) && (sl <= 4) && (n < NN);
      if (ok) cfg_m[n][sl] = ix;
      return !ok;
   endfunction

   function automatic exp_t build(input logic [NF*3-1:0] s, input int acc);
      exp_t e;
      int   v [5];
      e.acc = acc;
      for (int n = 0; n < NN; n++) begin
         for (int sl = 0; sl < 5; sl++) v[sl] = int'(s[3*cfg_m[n][sl] +: 3]);
         e.vec[n] = ((v[1] + v[2] + v[4]) > (v[0] + v[3]));
         e.ops[n] = {3'(v[0]), 3'(v[1]), 3'(v[2]), 3'(v[3]), 3'(v[4])};
      end
      return e;
   endfunction

   // Monitor: operands, valid timing, stability and the popped result vector.
   always @(negedge clk) begin
      int d, k;
      logic [14:0] eops;
      if (exp_q.size() == 0) begin
         chk("cmp_idle", 32'({cmp_a, cmp_b, cmp_c, cmp_d, cmp_e}), 32'd0);
         chk("valid_busy_idle", 32'({out_valid, busy}), 32'd0);
      end else begin
         d = cyc - exp_q[0].acc;
         k = d - PIPE;
         eops = (k >= 0 && k < NN) ? exp_q[0].ops[k] : 15'd0;
         chk("cmp_ops", 32'({cmp_a, cmp_b, cmp_c, cmp_d, cmp_e}), 32'(eops));
         chk("out_valid_timing", 32'(out_valid), 32'(d >= LAT));
         chk("busy_active", 32'(busy), 32'd1);
         chk("in_ready_active", 32'(in_ready), 32'd0);
         if (out_valid) begin
            chk("out_vec", 32'(out_vec), 32'(exp_q[0].vec));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (i == 200) chk("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send_sample(input logic [NF*3-1:0] s, input bit wcfg, input int n,
                              input int sl, input int ix);
      bit eerr;
      wait_ready();
      in_data = s;
      in_valid = 1'b1;
      if (wcfg) begin
         cfg_we = 1'b1; cfg_neuron = 3'(n); cfg_slot = 3'(sl); cfg_idx = 4'(ix);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cfg_we = 1'b0;
      if (wcfg) begin
         eerr = cfg_apply(n, sl, ix, 1'b1);
         chk("cfg_err_with_sample", 32'(cfg_err), 32'(eerr));
      end
      exp_q.push_back(build(s, cyc));
   endtask

   task automatic cfg_write(input int n, input int sl, input int ix, input bit idle);
      bit eerr;
      @(negedge clk);
      cfg_we = 1'b1; cfg_neuron = 3'(n); cfg_slot = 3'(sl); cfg_idx = 4'(ix);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      eerr = cfg_apply(n, sl, ix, idle);
      chk("cfg_err", 32'(cfg_err), 32'(eerr));
      @(posedge clk); #1;
      chk("cfg_err_pulse_end", 32'(cfg_err), 32'd0);
   endtask

   task automatic wait_done(input bit rnd);
      int i;
      for (i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !busy) break;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (i == 400) chk("done_timeout", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b0;
   endtask

   function automatic logic [NF*3-1:0] rand_sample();
      logic [NF*3-1:0] s;
      for (int f = 0; f < NF; f++) s[3*f +: 3] = 3'($urandom_range(0, 7));
      return s;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
      $fatal(1);
   end

   initial begin
      logic [NF*3-1:0] sa, s3, s2;
      int fa [NF];
      fa = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
      for (int f = 0; f < NF; f++) sa[3*f +: 3] = 3'(fa[f]);
      for (int f = 0; f < NF; f++) s3[3*f +: 3] = 3'd3;
      cfg_default();

      // Power-on reset
      #1 rst_n = 1'b0;
      #12;
      chk("reset_outputs", 32'({in_ready, cfg_err, cmp_a, cmp_b, cmp_c, cmp_d, cmp_e,
                                out_vec, out_valid, busy}), 32'd0);
      #11 rst_n = 1'b1;

      // Default table, directed sample
      send_sample(sa, 1'b0, 0, 0, 0);
      wait_done(1'b0);

      // Reprogram neuron 2 to features 10,10,10,0,0 then all-3 sample
      cfg_write(2, 0, 10, 1'b1);
      cfg_write(2, 1, 10, 1'b1);
      cfg_write(2, 2, 10, 1'b1);
      cfg_write(2, 3, 0, 1'b1);
      cfg_write(2, 4, 0, 1'b1);
      send_sample(s3, 1'b0, 0, 0, 0);
      wait_done(1'b0);

      // Reset in the middle of RUN (k=4)
      send_sample(sa, 1'b0, 0, 0, 0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      cfg_default();
      #1;
      chk("midrun_reset_outputs", 32'({in_ready, cfg_err, cmp_a, cmp_b, cmp_c, cmp_d, cmp_e,
                                      out_vec, out_valid, busy}), 32'd0);
      @(negedge clk); #3 rst_n = 1'b1;
      send_sample(sa, 1'b0, 0, 0, 0);
      wait_done(1'b0);

      // Rejected writes: bad index, bad slot, write during RUN
      cfg_write(0, 0, 11, 1'b1);
      cfg_write(1, 5, 3, 1'b1);
      send_sample(sa, 1'b0, 0, 0, 0);
      cfg_write(0, 0, 7, 1'b0);
      wait_done(1'b0);

      // Hold in DONE with a second sample pending
      s2 = rand_sample();
      send_sample(sa, 1'b0, 0, 0, 0);
      begin
         int i;
         for (i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) break;
         end
         if (i == 50) chk("hold_valid_timeout", 32'(out_valid), 32'd1);
      end
      in_data = s2;
      in_valid = 1'b1;
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_after_out_ready", 32'({busy, in_ready}), 32'b01);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(build(s2, cyc));
      chk("second_accept", 32'(busy), 32'd1);
      wait_done(1'b0);

      // Config write coinciding with sample acceptance
      send_sample(sa, 1'b1, 3, 4, 9);
      wait_done(1'b0);

      // Randomised traffic
      for (int it = 0; it < 25; it++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++)
            cfg_write($urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 13), 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         if ($urandom_range(0, 3) == 0)
            send_sample(rand_sample(), 1'b1, $urandom_range(0, 7), $urandom_range(0, 6),
                        $urandom_range(0, 13));
         else
            send_sample(rand_sample(), 1'b0, 0, 0, 0);
         wait_done(1'b1);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
